// File: rtl/config_rd_arbiter_pkg.sv
// Shared definitions for the neuron configuration memory read arbiter.
package config_rd_arbiter_pkg;

  // Default config memory address width (one address per neuron).
  localparam int NURN_CNT_BIT_WIDTH_DEF = 8;

  // Arbiter state encoding.
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Requester slot assignment on the shared port.
  localparam int REQ_NURN = 0;
  localparam int REQ_STDP = 1;
  localparam int REQ_DBG  = 2;

endpackage

// File: rtl/config_rd_arbiter_rr_pick.sv
// Circular priority picker: first set request at or after start, wrapping.
module config_rd_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan N slots starting at 'start'; the slot just before start is last.
  always_comb begin
    int k;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    k      = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(start) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        onehot[k] = 1'b1;
        idx       = IDX_W'(k);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/config_rd_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one config memory read port.
module config_rd_arbiter
  import config_rd_arbiter_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int NURN_CNT_BIT_WIDTH = NURN_CNT_BIT_WIDTH_DEF,
  parameter int MAX_BURST          = 4,
  parameter int BURST_CNT_W        = 3,
  localparam int OWN_W             = $clog2(NUM_REQ)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic [NUM_REQ-1:0]                    req_i,
  input  logic [NUM_REQ*NURN_CNT_BIT_WIDTH-1:0] addr_i,
  input  logic                                  hold_i,
  output logic [NUM_REQ-1:0]                    gnt_o,
  output logic [NUM_REQ-1:0]                    rsp_vld_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]         Addr_Config_o,
  output logic                                  rdEn_Config_o,
  output logic [OWN_W-1:0]                      owner_o
);

  arb_state_e               state_q, state_d;
  logic [OWN_W-1:0]         owner_q, owner_d, start_idx, pick_idx;
  logic [BURST_CNT_W-1:0]   burst_q, burst_d;
  logic [NUM_REQ-1:0]       pick_oh, gnt, rsp_vld_q;
  logic                     pick_any, keep;

  // owner_q doubles as last_owner in IDLE, so one rotation start serves both
  // states; the current owner ends up as the lowest-priority candidate.
  assign start_idx = (owner_q == OWN_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

  config_rd_arbiter_rr_pick #(.N(NUM_REQ), .IDX_W(OWN_W)) u_pick (
    .req    (req_i),
    .start  (start_idx),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign keep = (state_q == BURST) && req_i[owner_q] &&
                (burst_q < BURST_CNT_W'(MAX_BURST));

  // Next-state / grant: continue the burst, else rotate, else go idle.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    burst_d = burst_q;
    gnt     = '0;
    if (!hold_i) begin
      if (keep) begin
        gnt[owner_q] = 1'b1;
        burst_d      = burst_q + 1'b1;
      end else if (pick_any) begin
        gnt     = pick_oh;
        owner_d = pick_idx;
        burst_d = BURST_CNT_W'(1);
        state_d = BURST;
      end else begin
        state_d = IDLE;
        burst_d = '0;
      end
    end
  end

  // Grants are combinational from req_i, so gate them off during reset.
  assign gnt_o         = rst_n_i ? gnt : '0;
  assign rdEn_Config_o = |gnt_o;
  assign owner_o       = owner_q;
  assign rsp_vld_o     = rsp_vld_q;

  // Address mux: zero when idle so the memory address bus stays quiet.
  always_comb begin
    Addr_Config_o = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (gnt_o[k]) Addr_Config_o = Addr_Config_o |
                                    addr_i[k*NURN_CNT_BIT_WIDTH +: NURN_CNT_BIT_WIDTH];
  end

  // Arbitration state; reset leaves requester 0 first in line.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      owner_q <= OWN_W'(NUM_REQ-1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      burst_q <= burst_d;
    end
  end

  // Response strobe tracks the memory's output register, one cycle behind gnt.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rsp_vld_q <= '0;
    else          rsp_vld_q <= gnt_o;
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(gnt_o));

endmodule

// File: tb/tb_config_rd_arbiter.sv
// Directed, table-driven bench for config_rd_arbiter (4 requesters, burst 4).
module tb_config_rd_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam logic [7:0] A0 = 8'h12, A1 = 8'hB1, A2 = 8'hC2, A3 = 8'hD3;

  logic           clk_i = 1'b0;
  logic           rst_n_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] addr_i;
  logic           hold_i;
  logic [N-1:0]   gnt_o, rsp_vld_o;
  logic [W-1:0]   Addr_Config_o;
  logic           rdEn_Config_o;
  logic [1:0]     owner_o;

  config_rd_arbiter dut (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .hold_i        (hold_i),
    .gnt_o         (gnt_o),
    .rsp_vld_o     (rsp_vld_o),
    .Addr_Config_o (Addr_Config_o),
    .rdEn_Config_o (rdEn_Config_o),
    .owner_o       (owner_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       hold;
    logic [3:0] gnt;
    logic [3:0] rsp;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] exp_addr(input logic [3:0] g);
    case (g)
      4'b0001: return A0;
      4'b0010: return A1;
      4'b0100: return A2;
      4'b1000: return A3;
      default: return 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic h,
                     input logic [3:0] g, input logic [3:0] rs);
    vec_t v;
    v.rst = r; v.req = rq; v.hold = h; v.gnt = g; v.rsp = rs;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0; req_i = '0; hold_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g, gp;
    rst_n_i = 1'b0; req_i = '0; hold_i = 1'b0;
    addr_i  = {A3, A2, A1, A0};

    // Reset state, with a request present to confirm grants are gated off.
    #12;
    req_i = 4'b0001;
    #1;
    chk("rst_gnt",   32'(gnt_o), 32'h0);
    chk("rst_rsp",   32'(rsp_vld_o), 32'h0);
    chk("rst_rden",  32'(rdEn_Config_o), 32'h0);
    chk("rst_addr",  32'(Addr_Config_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h3);

    // 1: single request, response one cycle later.
    add(1, 4'b0001, 0, 4'b0001, 4'b0000);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001);
    // 2: all requesting, bursts of 4 rotating 0,1,2,3,0.
    gp = 4'b0000;
    for (int j = 0; j < 17; j++) begin
      g = 4'(1 << ((j / 4) % 4));
      add(j == 0, 4'b1111, 0, g, gp);
      gp = g;
    end
    add(0, 4'b0000, 0, 4'b0000, gp);
    // 3: lone requester is regranted every cycle across burst expiry.
    for (int j = 0; j < 10; j++)
      add(j == 0, 4'b0001, 0, 4'b0001, (j == 0) ? 4'b0000 : 4'b0001);
    add(0, 4'b0000, 0, 4'b0000, 4'b0001);
    // 4: owner 0 drops after two grants, requester 2 takes over same cycle.
    add(1, 4'b0101, 0, 4'b0001, 4'b0000);
    add(0, 4'b0101, 0, 4'b0001, 4'b0001);
    add(0, 4'b0100, 0, 4'b0100, 4'b0001);
    add(0, 4'b0100, 0, 4'b0100, 4'b0100);
    // 5: hold during owner-1 burst; burst resumes at count 3, then rotates to 3.
    add(1, 4'b0010, 0, 4'b0010, 4'b0000);
    add(0, 4'b0010, 0, 4'b0010, 4'b0010);
    add(0, 4'b1010, 1, 4'b0000, 4'b0010);
    add(0, 4'b1010, 1, 4'b0000, 4'b0000);
    add(0, 4'b1010, 1, 4'b0000, 4'b0000);
    add(0, 4'b1010, 0, 4'b0010, 4'b0000);
    add(0, 4'b1010, 0, 4'b0010, 4'b0010);
    add(0, 4'b1010, 0, 4'b1000, 4'b0010);
    add(0, 4'b0000, 0, 4'b0000, 4'b1000);

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      @(negedge clk_i);
      req_i  = vq[i].req;
      hold_i = vq[i].hold;
      #1;
      chk($sformatf("v%0d_gnt", i),  32'(gnt_o), 32'(vq[i].gnt));
      chk($sformatf("v%0d_rsp", i),  32'(rsp_vld_o), 32'(vq[i].rsp));
      chk($sformatf("v%0d_addr", i), 32'(Addr_Config_o), 32'(exp_addr(vq[i].gnt)));
      chk($sformatf("v%0d_rden", i), 32'(rdEn_Config_o), 32'(|vq[i].gnt));
    end

    // 6: reset in the cycle after a grant drops the pending response.
    do_reset();
    @(negedge clk_i);
    req_i = 4'b0001;
    #1;
    chk("t6_gnt0", 32'(gnt_o), 32'h1);
    @(negedge clk_i);
    #1;
    chk("t6_rsp_before", 32'(rsp_vld_o), 32'h1);
    rst_n_i = 1'b0;
    #1;
    chk("t6_rsp_cleared", 32'(rsp_vld_o), 32'h0);
    chk("t6_gnt_rst",     32'(gnt_o), 32'h0);
    chk("t6_rden_rst",    32'(rdEn_Config_o), 32'h0);
    chk("t6_addr_rst",    32'(Addr_Config_o), 32'h0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    req_i   = 4'b1010;
    #1;
    chk("t6_gnt_after", 32'(gnt_o), 32'h2);
    chk("t6_addr_after", 32'(Addr_Config_o), 32'(A1));
    @(posedge clk_i);
    #1;
    chk("t6_owner", 32'(owner_o), 32'h1);
    chk("t6_rsp",   32'(rsp_vld_o), 32'h2);
    req_i = '0;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_rd_arbiter.md
Name: config_rd_arbiter

Overview:
- Shares one read port of the neuron configuration memory (address plus read enable, 1-cycle registered read) among NUM_REQ requesters, e.g. neuron update pipeline, STDP learning unit and debug/readback.
- Round-robin arbitration with bounded bursts: a granted requester keeps the port for up to MAX_BURST consecutive cycles, then rotates.
- Produces per-requester grant and response-valid strobes aligned to the memory output register.
- Sits between the neuron controllers and the config memory, one instance per shared port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NURN_CNT_BIT_WIDTH, 8, config address width
- MAX_BURST, 4, max consecutive grants to one owner (>=1; 1 = pure round-robin)
- BURST_CNT_W, 3, burst counter width, must hold MAX_BURST

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester read request, level, held until granted
- addr_i  in  NUM_REQ*NURN_CNT_BIT_WIDTH  packed addresses; requester k uses slice k
- hold_i  in  1  freeze arbitration (e.g. config write in progress)
- gnt_o  out  NUM_REQ  one-hot grant, combinational, same cycle as accepted request
- rsp_vld_o  out  NUM_REQ  one-hot, registered; memory data valid for that requester this cycle
- Addr_Config_o  out  NURN_CNT_BIT_WIDTH  address to memory
- rdEn_Config_o  out  1  read enable to memory (= OR of gnt_o)
- owner_o  out  clog2(NUM_REQ)  current/last owner index (debug)

Behaviour:
- Clock/reset: single clock clk_i; reset asynchronous, active-low on rst_n_i.
- Reset values:
  - state=IDLE, last_owner=NUM_REQ-1 (requester 0 has first priority), burst_cnt=0, rsp_vld_o=0.
  - gnt_o=0, rdEn_Config_o=0 and Addr_Config_o=0 while in reset.
- States:
  - IDLE: no owner. Grant the first requester with req high, scanning circularly from last_owner+1.
    - On a grant: go to BURST, owner=winner, burst_cnt=1.
  - BURST: owner o.
    - If req_i[o]=1 and burst_cnt<MAX_BURST: grant o again, burst_cnt+1.
    - Else: round-robin from o+1, wrapping, with o itself as the lowest-priority candidate. Winner w: owner=w, burst_cnt=1.
    - If no requests: gnt_o=0, go to IDLE, last_owner=o.
- A burst expiring with only o requesting regrants o with burst_cnt=1. No bubble cycle.
- Owner dropping req mid-burst: re-arbitration in the same cycle. No idle cycle if another request is pending.
- hold_i=1:
  - gnt_o=0, rdEn_Config_o=0.
  - state, owner and burst_cnt frozen.
  - rsp_vld_o for a grant issued the previous cycle still asserts.
- Address: Addr_Config_o = addr_i slice of the granted requester. It is 0 when no grant, so the memory address does not toggle needlessly.
- Latency:
  - Grant in cycle t; memory samples on edge ending t.
  - rsp_vld_o[k]=1 in cycle t+1 only (one cycle per grant). Back-to-back grants give back-to-back rsp_vld.
- Requester protocol:
  - Deassert req or present a new addr in the cycle after gnt.
  - Capture memory data in the rsp_vld cycle; the memory register is overwritten by the next read.
- Reset mid-operation: pending response dropped (rsp_vld_o cleared); arbitration restarts with requester 0 priority.
- Out-of-range or X requests are not checked. A gnt_o that is not one-hot is an assertion failure.

Decomposition:
- Shared package (neuron config pkg): NURN_CNT_BIT_WIDTH default, arbiter state encoding (IDLE=1'b0, BURST=1'b1), requester index localparams (REQ_NURN=0, REQ_STDP=1, REQ_DBG=2).
- One sub-module: rr_pick. Combinational circular priority picker: inputs request vector and start index; outputs one-hot winner, index, any.
- Top: state/burst counter, address mux, response pipeline register.

Test Plan:
1. Reset, then req_i=4'b0001, addr0=8'h12 → cycle 0: gnt_o=0001, Addr=12, rdEn=1; cycle 1: rsp_vld_o=0001.
2. req_i=4'b1111 held, MAX_BURST=4 → grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; rsp_vld_o follows one cycle later.
3. MAX_BURST=4, only req0 held for 10 cycles → gnt0 every cycle, burst_cnt wraps 1..4, no bubbles.
4. req0,req2 high; owner 0 drops req at burst_cnt=2 → same cycle gnt_o=0100, burst_cnt=1.
5. hold_i=1 for 3 cycles during owner-1 burst (burst_cnt=2) → gnt_o=0, rdEn=0; previous-cycle rsp_vld still fires; after release, owner 1 resumes at burst_cnt=3.
6. Assert rst_n_i=0 in the cycle after a grant → rsp_vld_o=0 immediately; after release, req_i=4'b1010 → first grant goes to requester 1.
